// File: rtl/vseq_pkg.sv
// Shared types and constants for the vector memory sequencer.
// Holds the FSM state enum, lane geometry and the lane-index type.
package vseq_pkg;

   localparam int VSEQ_LANES   = 6;
   localparam int VSEQ_LANE_W  = 8;
   localparam int VSEQ_ADDR_W  = 16;
   localparam int VSEQ_LANE_IW = $clog2(VSEQ_LANES);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } vseq_state_t;

   typedef logic [VSEQ_LANE_IW-1:0] vseq_lane_t;

endpackage

// File: rtl/vseq_addr_gen.sv
// Lane address generator: latches base (and stride with VSEQ_STRIDE_EN),
// adds the stride on every ack. Ports: clk, rst (sync, low), load, step,
// base, [stride], addr.
module vseq_addr_gen
   import vseq_pkg::*;
#(
   parameter int ADDR_W = VSEQ_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] base,
`ifdef VSEQ_STRIDE_EN
   input  logic [ADDR_W-1:0] stride,
`endif
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] inc;

`ifdef VSEQ_STRIDE_EN
   logic [ADDR_W-1:0] stride_q;

   always_ff @(posedge clk) begin
      if (!rst)
         stride_q <= '0;
      else if (load)
         stride_q <= stride;
   end

   assign inc = stride_q;
`else
   assign inc = ADDR_W'(1);
`endif

   // Accumulator instead of base + lane*stride; wraps modulo 2^ADDR_W.
   always_ff @(posedge clk) begin
      if (!rst)
         addr_q <= '0;
      else if (load)
         addr_q <= base;
      else if (step)
         addr_q <= addr_q + inc;
   end

   assign addr = addr_q;

endmodule

// File: rtl/vector_mem_sequencer.sv
// Serializes a LANES x LANE_W vector load/store into byte accesses,
// stalling the pipeline until done. Optional macro: VSEQ_STRIDE_EN.
// Ports: start/isStore/baseAddr/wdata[/stride] in; mem* handshake;
// stall, done, rdata out.
module vector_mem_sequencer
   import vseq_pkg::*;
#(
   parameter int LANES  = VSEQ_LANES,
   parameter int LANE_W = VSEQ_LANE_W,
   parameter int ADDR_W = VSEQ_ADDR_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    isStore,
   input  logic [ADDR_W-1:0]       baseAddr,
   input  logic [LANES*LANE_W-1:0] wdata,
`ifdef VSEQ_STRIDE_EN
   input  logic [ADDR_W-1:0]       stride,
`endif
   input  logic [LANE_W-1:0]       memRdata,
   input  logic                    memAck,
   output logic                    memReq,
   output logic                    memWe,
   output logic [ADDR_W-1:0]       memAddr,
   output logic [LANE_W-1:0]       memWdata,
   output logic                    stall,
   output logic                    done,
   output logic [LANES*LANE_W-1:0] rdata
);

   vseq_state_t state_q;
   vseq_state_t state_d;

   vseq_lane_t              lane_q;
   logic                    store_q;
   logic [LANES*LANE_W-1:0] wdata_q;
   logic [LANES*LANE_W-1:0] rdata_q;

   logic accept;
   logic step;
   logic last;

   assign accept = (state_q == IDLE) && start;
   assign step   = (state_q == ACCESS) && memAck;
   assign last   = (lane_q == vseq_lane_t'(LANES - 1));

   always_ff @(posedge clk) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = ACCESS;
         ACCESS:  if (memAck && last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      memReq   = 1'b0;
      memWe    = 1'b0;
      memWdata = '0;
      stall    = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         IDLE: stall = start;
         ACCESS: begin
            memReq   = 1'b1;
            memWe    = store_q;
            memWdata = wdata_q[lane_q*LANE_W +: LANE_W];
            stall    = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Load bytes land as they are acked; a store never touches rdata.
   always_ff @(posedge clk) begin
      if (!rst) begin
         lane_q  <= '0;
         store_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else if (accept) begin
         lane_q  <= '0;
         store_q <= isStore;
         wdata_q <= wdata;
      end else if (step) begin
         lane_q <= lane_q + vseq_lane_t'(1);
         if (!store_q)
            rdata_q[lane_q*LANE_W +: LANE_W] <= memRdata;
      end
   end

   assign rdata = rdata_q;

   vseq_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .step   (step),
      .base   (baseAddr),
`ifdef VSEQ_STRIDE_EN
      .stride (stride),
`endif
      .addr   (memAddr)
   );

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Randomized bench for vector_mem_sequencer against a transaction model.
// Honours VSEQ_STRIDE_EN for the stride port and the stride scenario.
module tb_vector_mem_sequencer;

   localparam int LANES  = 6;
   localparam int LANE_W = 8;
   localparam int ADDR_W = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        isStore = 1'b0;
   logic [15:0] baseAddr = '0;
   logic [15:0] stride = 16'd1;
   logic [47:0] wdata = '0;
   logic [7:0]  memRdata = '0;
   logic        memAck = 1'b0;
   logic        memReq;
   logic        memWe;
   logic [15:0] memAddr;
   logic [7:0]  memWdata;
   logic        stall;
   logic        done;
   logic [47:0] rdata;

   always #5 clk = ~clk;

   vector_mem_sequencer #(
      .LANES  (LANES),
      .LANE_W (LANE_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .isStore  (isStore),
      .baseAddr (baseAddr),
      .wdata    (wdata),
`ifdef VSEQ_STRIDE_EN
      .stride   (stride),
`endif
      .memRdata (memRdata),
      .memAck   (memAck),
      .memReq   (memReq),
      .memWe    (memWe),
      .memAddr  (memAddr),
      .memWdata (memWdata),
      .stall    (stall),
      .done     (done),
      .rdata    (rdata)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_done = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Transaction-level model: an op is a list of six lane accesses.
   logic [7:0]  mem [0:65535];
   bit          act;
   bit          dn;
   bit          after_rst;
   bit          st_m;
   int          k;
   int          wcnt;
   int          wmode;
   logic [15:0] base_m;
   logic [15:0] str_m;
   logic [47:0] wd_m;
   logic [47:0] rd_m;

   function automatic int next_wait();
      return (wmode >= 0) ? wmode : int'($urandom_range(0, 3));
   endfunction

   function automatic logic [15:0] lane_addr(input int lane);
      return base_m + 16'(lane) * str_m;
   endfunction

   task automatic cycle();
      logic [15:0] a;
      logic [15:0] oa;
      logic [7:0]  ow;
      a = lane_addr(k);
      if (act) begin
         memAck   = (wcnt == 0);
         memRdata = mem[a];
      end else begin
         memAck   = ($urandom_range(0, 3) == 0);
         memRdata = 8'($urandom);
      end
      #1;
      oa = memAddr;
      ow = memWdata;
      chk("memReq", {63'd0, memReq}, {63'd0, act});
      chk("done", {63'd0, done}, {63'd0, dn});
      chk("stall", {63'd0, stall}, {63'd0, act | (!act && !dn && start)});
      chk("rdata", {16'd0, rdata}, {16'd0, rd_m});
      if (act) begin
         chk("memAddr", {48'd0, memAddr}, {48'd0, a});
         chk("memWe", {63'd0, memWe}, {63'd0, st_m});
         chk("memWdata", {56'd0, memWdata}, {56'd0, wd_m[k*8 +: 8]});
      end
      if (after_rst) begin
         chk("rst_addr", {48'd0, memAddr}, 64'd0);
         chk("rst_wdata", {56'd0, memWdata}, 64'd0);
         chk("rst_we", {63'd0, memWe}, 64'd0);
      end
      if (done === 1'b1)
         n_done++;
      @(posedge clk);
      if (!rst) begin
         act = 0; dn = 0; k = 0; rd_m = '0; after_rst = 1;
      end else begin
         after_rst = 0;
         if (dn) begin
            dn = 0;
         end else if (act) begin
            if (memAck) begin
               if (st_m)
                  mem[oa] = ow;
               else
                  rd_m[k*8 +: 8] = memRdata;
               k++;
               if (k == LANES) begin
                  act = 0;
                  dn  = 1;
               end else begin
                  wcnt = next_wait();
               end
            end else begin
               wcnt--;
            end
         end else if (start) begin
            act    = 1;
            k      = 0;
            st_m   = isStore;
            base_m = baseAddr;
            wd_m   = wdata;
`ifdef VSEQ_STRIDE_EN
            str_m  = stride;
`else
            str_m  = 16'd1;
`endif
            wcnt   = next_wait();
         end
      end
      #1;
   endtask

   task automatic run_op(input bit st, input logic [15:0] b,
                         input logic [47:0] w, input logic [15:0] s,
                         input int wm, input int busy_at,
                         input int rst_at, output int done_at);
      done_at = -1;
      wmode   = wm;
      for (int c = 0; c < 200; c++) begin
         rst      = !(c == rst_at);
         start    = (c == 0) || (c == busy_at);
         isStore  = (c == 0) ? st : ~st;
         baseAddr = (c == 0) ? b : 16'h0200;
         wdata    = (c == 0) ? w : ~w;
         stride   = (c == 0) ? s : s + 16'd3;
         if (dn)
            done_at = c;
         cycle();
         if (done_at >= 0 || c == rst_at)
            break;
      end
      start = 1'b0;
      rst   = 1'b1;
      if (rst_at < 0)
         chk("op_done", {63'd0, done_at >= 0}, 64'd1);
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      for (int i = 0; i < n; i++)
         cycle();
   endtask

   int          d;
   int          nd0;
   logic [47:0] exp_v;

   initial begin
      for (int i = 0; i < 65536; i++)
         mem[i] = 8'($urandom);
      act = 0; dn = 0; k = 0; rd_m = '0; after_rst = 0;
      wmode = 0; wcnt = 0; st_m = 0;
      base_m = '0; str_m = 16'd1; wd_m = '0;
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++)
         cycle();
      rst = 1'b1;
      idle(2);

      // zero-wait store
      run_op(1, 16'h0010, 48'h665544332211, 16'd1, 0, -1, -1, d);
      chk("st_done_cyc", 64'(d), 64'd7);
      for (int i = 0; i < LANES; i++)
         chk("st_mem", {56'd0, mem[16'h0010 + 16'(i)]},
             64'(8'h11 * (i + 1)));
      idle(2);

      // load with two waits per lane
      for (int i = 0; i < LANES; i++)
         mem[16'h0100 + 16'(i)] = 8'hA0 + 8'(i);
      run_op(0, 16'h0100, 48'h123456789ABC, 16'd1, 2, -1, -1, d);
      chk("ld_done_cyc", 64'(d), 64'd19);
      chk("ld_rdata", {16'd0, rdata}, 64'h0000A5A4A3A2A1A0);
      idle(1);

      // address wrap
      for (int i = 0; i < LANES; i++)
         exp_v[i*8 +: 8] = mem[16'hFFFD + 16'(i)];
      run_op(0, 16'hFFFD, 48'h0, 16'd1, 1, -1, -1, d);
      chk("wrap_rdata", {16'd0, rdata}, {16'd0, exp_v});
      idle(1);

      // start while busy is ignored
      nd0 = n_done;
      run_op(1, 16'h0300, 48'hCAFEBABE0102, 16'd1, 0, 3, -1, d);
      chk("busy_done_cyc", 64'(d), 64'd7);
      idle(4);
      chk("busy_one_done", 64'(n_done - nd0), 64'd1);

      // reset in the middle of a load
      nd0 = n_done;
      run_op(0, 16'h0400, 48'h0, 16'd1, 1, -1, 4, d);
      idle(3);
      chk("rst_rdata", {16'd0, rdata}, 64'd0);
      chk("rst_no_done", 64'(n_done - nd0), 64'd0);
      run_op(0, 16'h0500, 48'h0, 16'd1, 0, -1, -1, d);
      chk("post_rst_cyc", 64'(d), 64'd7);
      idle(1);

`ifdef VSEQ_STRIDE_EN
      run_op(0, 16'h0020, 48'h0, 16'd4, 0, -1, -1, d);
      chk("stride_cyc", 64'(d), 64'd7);
      idle(1);
      run_op(1, 16'h0040, 48'hF1F2F3F4F5F6, 16'd0, 1, -1, -1, d);
      chk("stride0_mem", {56'd0, mem[16'h0040]}, 64'hF1);
      idle(1);
`endif

      // randomized traffic
      for (int t = 0; t < 30; t++) begin
         run_op(1'($urandom), 16'($urandom),
                {16'($urandom), $urandom}, 16'($urandom_range(0, 9)),
                -1, ($urandom_range(0, 1) != 0) ? 2 : -1, -1, d);
         idle(int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
